// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry skid buffer.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready with in_instr and in_tag;
//   out_valid/out_ready with out_imm, out_type, out_instr and out_tag.
// Option: define IMM_GEN_ZIMM_EN to decode csrr*i as type 5 with a zero-extended zimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] T_I    = 3'd0;
  localparam logic [2:0] T_S    = 3'd1;
  localparam logic [2:0] T_B    = 3'd2;
  localparam logic [2:0] T_U    = 3'd3;
  localparam logic [2:0] T_J    = 3'd4;
  localparam logic [2:0] T_NONE = 3'd7;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] T_Z    = 3'd5;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [6:0] w_op;
  logic       w_is_i;
  logic       w_is_s;
  logic       w_is_b;
  logic       w_is_u;
  logic       w_is_j;
  ent_t       w_new;
  logic       w_in_fire;
  logic       w_drain;

  ent_t r_main;
  ent_t r_skid;
  logic r_main_valid;
  logic r_skid_valid;

  assign w_op   = in_instr[6:0];
  assign w_is_i = (w_op == OP_IMM) || (w_op == OP_LOAD) ||
                  (w_op == OP_JALR) || (w_op == OP_SYS) ||
                  ((XLEN == 64) && (w_op == OP_IMM32));
  assign w_is_s = (w_op == OP_STORE);
  assign w_is_b = (w_op == OP_BR);
  assign w_is_u = (w_op == OP_LUI) || (w_op == OP_AUIPC);
  assign w_is_j = (w_op == OP_JAL);

  always_comb begin
    w_new.imm   = '0;
    w_new.typ   = T_NONE;
    w_new.instr = in_instr;
    w_new.tag   = in_tag;
    unique case (1'b1)
      w_is_i: begin
        w_new.typ = T_I;
        w_new.imm = XLEN'($signed(in_instr[31:20]));
`ifdef IMM_GEN_ZIMM_EN
        // csrr*i carry an unsigned 5-bit zimm in the rs1 field
        if (w_op == OP_SYS && in_instr[14]) begin
          w_new.typ = T_Z;
          w_new.imm = XLEN'(in_instr[19:15]);
        end
`endif
      end
      w_is_s: begin
        w_new.typ = T_S;
        w_new.imm = XLEN'($signed({in_instr[31:25],
                                   in_instr[11:7]}));
      end
      w_is_b: begin
        w_new.typ = T_B;
        w_new.imm = XLEN'($signed({in_instr[31],
                                   in_instr[7],
                                   in_instr[30:25],
                                   in_instr[11:8],
                                   1'b0}));
      end
      w_is_u: begin
        w_new.typ = T_U;
        w_new.imm = XLEN'($signed({in_instr[31:12],
                                   12'b0}));
      end
      w_is_j: begin
        w_new.typ = T_J;
        w_new.imm = XLEN'($signed({in_instr[31],
                                   in_instr[19:12],
                                   in_instr[20],
                                   in_instr[30:21],
                                   1'b0}));
      end
      default: ;
    endcase
  end

  assign in_ready  = !r_skid_valid;
  assign w_in_fire = in_valid && !r_skid_valid;
  // main may be overwritten when empty or being consumed
  assign w_drain   = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) r_main <= w_new;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid = r_main_valid;
  assign out_imm   = r_main.imm;
  assign out_type  = r_main.typ;
  assign out_instr = r_main.instr;
  assign out_tag   = r_main.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors against XLEN=32 and XLEN=64 instances
// driven from the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] imm32, ins32, tag32, ins64, tag64;
  logic [63:0] imm64;
  logic [2:0]  typ32, typ64;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_type(typ32),
    .out_instr(ins32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(typ64),
    .out_instr(ins64), .out_tag(tag64));

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i,
                     input logic [31:0] t);
    in_valid = 1'b1;
    in_instr = i;
    in_tag   = t;
  endtask

  // check the 32-bit instance's presented result
  task automatic o32(input string tag,
                     input logic [31:0] imm,
                     input logic [2:0] typ,
                     input logic [31:0] t);
    chk({tag, ".valid"}, 64'(vld32), 64'd1);
    chk({tag, ".imm"}, 64'(imm32), 64'(imm));
    chk({tag, ".type"}, 64'(typ32), 64'(typ));
    chk({tag, ".tag"}, 64'(tag32), 64'(t));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_tag = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.valid", 64'(vld32), 64'd0);
    chk("rst.imm", 64'(imm32), 64'd0);
    chk("rst.type", 64'(typ32), 64'd0);
    chk("rst.instr", 64'(ins32), 64'd0);
    chk("rst.tag", 64'(tag32), 64'd0);
    chk("rst.ready", 64'(rdy32), 64'd1);
    chk("rst.imm64", imm64, 64'd0);
    chk("rst.valid64", 64'(vld64), 64'd0);

    // addi x1,x0,-1
    put(32'hFFF00093, 32'h100);
    tick();
    o32("addi", 32'hFFFFFFFF, 3'd0, 32'h100);
    chk("addi.instr", 64'(ins32), 64'hFFF00093);
    chk("addi.imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

    // back-to-back, no bubbles
    put(32'h12345037, 32'h104);
    tick();
    o32("lui", 32'h12345000, 3'd3, 32'h104);
    put(32'hFE000EE3, 32'h108);
    tick();
    o32("beq", 32'hFFFFFFFC, 3'd2, 32'h108);
    chk("beq.imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    put(32'h0080006F, 32'h10C);
    tick();
    o32("jal", 32'h00000008, 3'd4, 32'h10C);
    put(32'h00112423, 32'h110);
    tick();
    o32("sw", 32'h00000008, 3'd1, 32'h110);
    in_valid = 1'b0;
    tick();
    chk("idle.valid", 64'(vld32), 64'd0);

    // back-pressure: 3 offered, 2 accepted
    out_ready = 1'b0;
    put(32'h00500093, 32'hA);
    tick();
    o32("bp.a", 32'd5, 3'd0, 32'hA);
    chk("bp.a.ready", 64'(rdy32), 64'd1);
    put(32'h00A00093, 32'hB);
    tick();
    o32("bp.b", 32'd5, 3'd0, 32'hA);
    chk("bp.b.ready", 64'(rdy32), 64'd0);
    put(32'h00F00093, 32'hC);
    tick();
    o32("bp.c", 32'd5, 3'd0, 32'hA);
    chk("bp.c.ready", 64'(rdy32), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    o32("bp.drain1", 32'd10, 3'd0, 32'hB);
    chk("bp.drain1.ready", 64'(rdy32), 64'd1);
    tick();
    chk("bp.drain2.valid", 64'(vld32), 64'd0);

    // flush with both entries full and an input offered
    out_ready = 1'b0;
    put(32'h00500093, 32'h1A);
    tick();
    put(32'h00A00093, 32'h1B);
    tick();
    chk("fl.full.ready", 64'(rdy32), 64'd0);
    flush = 1'b1;
    put(32'h00F00093, 32'h1C);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 64'(vld32), 64'd0);
    chk("fl.ready", 64'(rdy32), 64'd1);
    chk("fl.valid64", 64'(vld64), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fl.after.valid", 64'(vld32), 64'd0);

    // lui with bit 31 set: sign extends at XLEN=64
    put(32'h800000B7, 32'h200);
    tick();
    o32("lui.neg", 32'h80000000, 3'd3, 32'h200);
    chk("lui.neg.imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui.neg.type64", 64'(typ64), 64'd3);

    // R-type add
    put(32'h002081B3, 32'h204);
    tick();
    o32("add", 32'h0, 3'd7, 32'h204);
    chk("add.imm64", imm64, 64'h0);
    chk("add.type64", 64'(typ64), 64'd7);

    // addiw: I-type only at XLEN=64
    put(32'h0010809B, 32'h208);
    tick();
    o32("addiw32", 32'h0, 3'd7, 32'h208);
    chk("addiw64.type", 64'(typ64), 64'd0);
    chk("addiw64.imm", imm64, 64'd1);

    // csrrwi x0, 0x340, 3
    put(32'h3401D073, 32'h20C);
    tick();
`ifdef IMM_GEN_ZIMM_EN
    o32("csrrwi", 32'd3, 3'd5, 32'h20C);
    chk("csrrwi.imm64", imm64, 64'd3);
`else
    o32("csrrwi", 32'h340, 3'd0, 32'h20C);
    chk("csrrwi.imm64", imm64, 64'h340);
`endif

    // csrrw stays I-type either way; csr 0xFFF sign-extends
    put(32'hFFF09073, 32'h210);
    tick();
    o32("csrrw", 32'hFFFFFFFF, 3'd0, 32'h210);
    in_valid = 1'b0;
    tick();
    chk("end.valid", 64'(vld32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
